button_debounce: RTL and testbench
==================================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The block SHALL have parameter N_KEYS, default 3: the number of independent key channels.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000: the stability window in clocks (10 ms at 100 MHz).
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 50000000: the hold time before the first auto-repeat.
REQ-004 The block SHALL have parameter REPEAT_CYCLES, default 20000000: the auto-repeat period.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock. All logic is on the rising edge.
REQ-006 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port key_i, input, N_KEYS bits: raw asynchronous push-buttons, active-low (0 = pressed).
REQ-008 The block SHALL have port btn_o, output, N_KEYS bits: debounced level, active-high (1 = pressed).
REQ-009 The block SHALL have port ondn_o, output, N_KEYS bits: a one-cycle pulse on a debounced press, and on each auto-repeat.
REQ-010 The block SHALL have port onup_o, output, N_KEYS bits: a one-cycle pulse on a debounced release.

Function
REQ-011 Each key_i bit SHALL pass through a 2-flop synchronizer and then be inverted to active-high before any other use.
REQ-012 Each channel SHALL run an independent FSM with states IDLE, PRESS_CHK, HELD and REL_CHK.
REQ-013 The FSM transitions SHALL be:
- IDLE -> PRESS_CHK when the synchronized level is 1.
- PRESS_CHK -> IDLE when the level returns to 0 before the window completes.
- PRESS_CHK -> HELD when the level has been 1 for DEBOUNCE_CYCLES consecutive cycles.
- HELD -> REL_CHK when the level is 0.
- REL_CHK -> HELD when the level returns to 1 before the window completes.
- REL_CHK -> IDLE when the level has been 0 for DEBOUNCE_CYCLES consecutive cycles.
REQ-014 The stability counter SHALL clear on every entry to PRESS_CHK or REL_CHK, and on any abort of either state.
REQ-015 The counter SHALL be sized to $clog2(max(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES))+1 bits and SHALL never wrap.
REQ-016 btn_o[k] SHALL be 1 exactly when channel k is in HELD or REL_CHK.
REQ-017 ondn_o[k] SHALL be high for exactly one cycle, on the same edge where btn_o[k] rises.
REQ-018 onup_o[k] SHALL be high for exactly one cycle, on the same edge where btn_o[k] falls.
REQ-019 Latency from the first clk_i edge that samples a new stable key_i level to the btn_o change SHALL be exactly DEBOUNCE_CYCLES+2 cycles.
REQ-020 A key_i glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no output change.
REQ-021 Channels SHALL be fully independent; simultaneous events on several keys SHALL pulse in the same cycle.
REQ-022 ondn_o[k] and onup_o[k] SHALL never be high in the same cycle.

Reset
REQ-023 While rst_i=1 at a clock edge:
- synchronizer flops SHALL load 1 (released);
- all FSMs SHALL go to IDLE;
- all counters SHALL go to 0;
- btn_o, ondn_o and onup_o SHALL be 0 after that edge.
REQ-024 Reset asserted mid-debounce or mid-hold SHALL abort the operation and SHALL NOT emit onup_o.
REQ-025 A key held through reset release SHALL be reported pressed after the full DEBOUNCE_CYCLES+2 latency counted from the first edge with rst_i=0.

Configuration
REQ-026 With macro BUTTON_DEBOUNCE_AUTOREPEAT_EN defined:
- in HELD with the level still 1, ondn_o[k] SHALL additionally pulse HOLD_CYCLES cycles after the press pulse, then every REPEAT_CYCLES cycles while held;
- the repeat timer SHALL clear on leaving HELD;
- REL_CHK SHALL suspend repeats.
REQ-027 Without BUTTON_DEBOUNCE_AUTOREPEAT_EN, ondn_o SHALL pulse only once per debounced press, and HOLD_CYCLES and REPEAT_CYCLES SHALL be unused.

Verification
Bench parameters: DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=5.
REQ-028 key_i[0] driven 0 at edge 0 and held -> ondn_o[0]=1 only at edge 6; btn_o[0]=1 from edge 6; no other pulses.
REQ-029 key_i[1] low for 3 cycles, then high -> btn_o, ondn_o and onup_o stay 0 throughout.
REQ-030 Key pressed, then released at edge 20 -> onup_o=1 only at edge 26; btn_o=0 from edge 26.
REQ-031 key_i[0] and key_i[2] falling on the same edge -> ondn_o=3'b101 at edge 6.
REQ-032 rst_i=1 at edge 4 of a press, key kept low -> all outputs 0 at edge 4; ondn_o pulses at edge 11 if rst_i falls before edge 5.
REQ-033 Macro defined, key held 30 cycles from edge 0 -> ondn_o pulses at edges 6, 16, 21, 26; without the macro -> a pulse at edge 6 only.

Source files
------------

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - multi-key push-button debouncer with press/release pulses and optional auto-repeat
//
// Ports:
//   clk_i   - single clock, rising edge
//   rst_i   - synchronous active-high reset
//   key_i   - raw asynchronous buttons, active-low (0 = pressed)
//   btn_o   - debounced level, active-high (1 = pressed)
//   ondn_o  - one-cycle pulse on debounced press (and on each auto-repeat)
//   onup_o  - one-cycle pulse on debounced release
//
// Optional feature: define BUTTON_DEBOUNCE_AUTOREPEAT_EN to enable auto-repeat
// pulses on ondn_o while a key stays held.

module button_debounce #(
    parameter int N_KEYS          = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 20000000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N_KEYS-1:0] key_i,
    output logic [N_KEYS-1:0] btn_o,
    output logic [N_KEYS-1:0] ondn_o,
    output logic [N_KEYS-1:0] onup_o
);

    localparam int MAX_DH = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_C  = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
    localparam int CW     = $clog2(MAX_C) + 1;

    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
    localparam logic [CW-1:0] HD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_e;

    // Two-flop synchronizer; reset loads the released (high) level.
    logic [N_KEYS-1:0] sync1_q;
    logic [N_KEYS-1:0] sync2_q;
    logic [N_KEYS-1:0] level;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
        end
    end

    assign level = ~sync2_q;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        state_e        state_q;
        logic [CW-1:0] cnt_q;
        logic          btn_q;
        logic          ondn_q;
        logic          onup_q;
`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
        // 0: waiting for the first (hold) repeat, 1: periodic repeats
        logic          rpt_q;
`endif

        // cnt_q is the debounce window in the check states and the repeat
        // timer in HELD; it always restarts from 0 on a state change and stops
        // at its terminal value, so it cannot wrap.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                btn_q   <= 1'b0;
                ondn_q  <= 1'b0;
                onup_q  <= 1'b0;
`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
                rpt_q   <= 1'b0;
`endif
            end else begin
                ondn_q <= 1'b0;
                onup_q <= 1'b0;
                case (state_q)
                    IDLE: begin
                        if (level[g]) begin
                            state_q <= PRESS_CHK;
                            cnt_q   <= '0;
                        end
                    end
                    PRESS_CHK: begin
                        if (!level[g]) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else if (cnt_q == DB_LAST) begin
                            state_q <= HELD;
                            cnt_q   <= '0;
                            btn_q   <= 1'b1;
                            ondn_q  <= 1'b1;
`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
                            rpt_q   <= 1'b0;
`endif
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    HELD: begin
                        if (!level[g]) begin
                            state_q <= REL_CHK;
                            cnt_q   <= '0;
`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
                            rpt_q   <= 1'b0;
`endif
                        end
`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
                        else if (cnt_q == (rpt_q ? RP_LAST : HD_LAST)) begin
                            ondn_q <= 1'b1;
                            cnt_q  <= '0;
                            rpt_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
`endif
                    end
                    REL_CHK: begin
                        if (level[g]) begin
                            state_q <= HELD;
                            cnt_q   <= '0;
                        end else if (cnt_q == DB_LAST) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            btn_q   <= 1'b0;
                            onup_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        btn_q   <= 1'b0;
                    end
                endcase
            end
        end

        assign btn_o[g]  = btn_q;
        assign ondn_o[g] = ondn_q;
        assign onup_o[g] = onup_q;
    end

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - self-checking bench for button_debounce

module tb_button_debounce;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [2:0] key_i;
    logic [2:0] btn_o;
    logic [2:0] ondn_o;
    logic [2:0] onup_o;

    always #5 clk = ~clk;

    button_debounce #(
        .N_KEYS         (3),
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (10),
        .REPEAT_CYCLES  (5)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .key_i (key_i),
        .btn_o (btn_o),
        .ondn_o(ondn_o),
        .onup_o(onup_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string      name;
        logic [2:0] mask;     // keys pressed in this vector
        int         low_len;  // key low for edges 0 .. low_len-1
        int         n_edges;  // edges observed
        int         dn_edge;  // press pulse edge, -1 = none
        int         up_edge;  // release pulse edge, -1 = none
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int e, input logic [2:0] act, input logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s edge %0d: got %b expected %b", name, e, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int e,
                              input logic [2:0] b, input logic [2:0] d, input logic [2:0] u);
        check({tag, ".btn"},  e, btn_o,  b);
        check({tag, ".ondn"}, e, ondn_o, d);
        check({tag, ".onup"}, e, onup_o, u);
        check({tag, ".excl"}, e, ondn_o & onup_o, 3'b000);
    endtask

    // Returns just after the next rising edge; outputs then hold that edge's values.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        key_i = 3'b111;
        rst_i = 1'b1;
        tick();
        check_outs("reset", 0, 3'b000, 3'b000, 3'b000);
        tick();
        rst_i = 1'b0;
        tick();
        tick();
    endtask

    function automatic logic [2:0] exp_ondn(input vec_t v, input int e);
        if (v.dn_edge >= 0 && e == v.dn_edge) return v.mask;
`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
        // Repeats at press+10, then every 5, while HELD still sees the key low
        // (level reaches the FSM two edges after key_i rises).
        if (v.dn_edge >= 0 && e >= v.dn_edge + 10 && ((e - v.dn_edge - 10) % 5) == 0
            && e <= v.low_len + 1) return v.mask;
`endif
        return 3'b000;
    endfunction

    function automatic logic [2:0] exp_btn(input vec_t v, input int e);
        if (v.dn_edge >= 0 && e >= v.dn_edge && (v.up_edge < 0 || e < v.up_edge)) return v.mask;
        return 3'b000;
    endfunction

    function automatic logic [2:0] exp_onup(input vec_t v, input int e);
        if (v.up_edge >= 0 && e == v.up_edge) return v.mask;
        return 3'b000;
    endfunction

    initial begin
        vecs[0] = '{"press_hold",   3'b001, 100, 15,  6, -1};
        vecs[1] = '{"glitch3",      3'b010,   3, 12, -1, -1};
        vecs[2] = '{"press_release",3'b001,  20, 30,  6, 26};
        vecs[3] = '{"simultaneous", 3'b101, 100, 10,  6, -1};
        vecs[4] = '{"hold30",       3'b001,  30, 31,  6, -1};
        vecs[5] = '{"min_press",    3'b100,   5, 14,  6, 11};

        rst_i = 1'b1;
        key_i = 3'b111;

        for (int i = 0; i < 6; i++) begin
            apply_reset();
            for (int e = 0; e < vecs[i].n_edges; e++) begin
                key_i = (e < vecs[i].low_len) ? ~vecs[i].mask : 3'b111;
                tick();
                check_outs(vecs[i].name, e, exp_btn(vecs[i], e),
                           exp_ondn(vecs[i], e), exp_onup(vecs[i], e));
            end
        end

        // Reset at edge 4 of a press, key kept low: restart, press at edge 11.
        apply_reset();
        for (int e = 0; e <= 12; e++) begin
            key_i = 3'b110;
            rst_i = (e == 4);
            tick();
            check_outs("reset_mid_press", e,
                       (e >= 11) ? 3'b001 : 3'b000,
                       (e == 11) ? 3'b001 : 3'b000,
                       3'b000);
        end
        rst_i = 1'b0;

        // Reset while held, key released together with reset: no release pulse.
        apply_reset();
        for (int e = 0; e <= 8; e++) begin
            key_i = 3'b101;
            tick();
            check_outs("hold_pre_reset", e,
                       (e >= 6) ? 3'b010 : 3'b000,
                       (e == 6) ? 3'b010 : 3'b000,
                       3'b000);
        end
        key_i = 3'b111;
        rst_i = 1'b1;
        tick();
        check_outs("reset_mid_hold", 9, 3'b000, 3'b000, 3'b000);
        rst_i = 1'b0;
        for (int e = 10; e < 20; e++) begin
            tick();
            check_outs("post_reset_hold", e, 3'b000, 3'b000, 3'b000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
